// File: rtl/phy_tx_lanes.sv
// Byte-striping serial transmitter: spreads WORD_W-bit words across NUM_LANES lanes,
// sending a COM preamble after reset and IDLE fill whenever no word is waiting.
module phy_tx_lanes #(
  parameter int         WORD_W     = 32,
  parameter int         NUM_LANES  = 2,
  parameter logic [7:0] COM_BYTE   = 8'hBC,
  parameter logic [7:0] IDLE_BYTE  = 8'h7C,
  parameter int         SYNC_SLOTS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    data_in_tx,
  input  logic                 valid_in_tx,
  output logic                 ready_out_tx,
  output logic [NUM_LANES-1:0] data_out_tx,
  output logic                 active_out_tx
);
  localparam int BPL    = WORD_W / (8 * NUM_LANES);
  localparam int SLOT   = 8 * BPL;
  localparam int CNT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int SYNC_W = (SYNC_SLOTS > 0) ? $clog2(SYNC_SLOTS + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SLOT - 1);
  localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_SLOTS - 1);

  if (WORD_W <= 0 || NUM_LANES <= 0 || (WORD_W % (8 * NUM_LANES)) != 0) begin : g_bad_width
    $error("phy_tx_lanes: WORD_W must be a positive multiple of 8*NUM_LANES");
  end
  if (SYNC_SLOTS < 1) begin : g_bad_sync
    $error("phy_tx_lanes: SYNC_SLOTS must be at least 1");
  end

  typedef enum logic {ST_SYNC, ST_RUN} state_t;
  typedef logic [NUM_LANES-1:0][SLOT-1:0] lanes_t;

  // Byte k goes to lane k%NUM_LANES, at position k/NUM_LANES within that lane's slot.
  function automatic lanes_t stripe(input logic [WORD_W-1:0] w);
    lanes_t s;
    s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int j = 0; j < BPL; j++) begin
        s[l][SLOT-1-8*j -: 8] = w[WORD_W-1-8*(l+j*NUM_LANES) -: 8];
      end
    end
    return s;
  endfunction

  function automatic lanes_t fill(input logic [7:0] b);
    lanes_t s;
    s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int j = 0; j < BPL; j++) begin
        s[l][SLOT-1-8*j -: 8] = b;
      end
    end
    return s;
  endfunction

  state_t              r_state;
  logic [SYNC_W-1:0]   r_sync_cnt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_hold_full;
  logic [WORD_W-1:0]   r_hold;
  lanes_t              r_shift;
  logic                r_active;
  logic                w_accept;

  assign ready_out_tx  = (r_state == ST_RUN) && !r_hold_full;
  assign w_accept      = valid_in_tx && ready_out_tx;
  assign active_out_tx = r_active;

  always_comb begin
    data_out_tx = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      data_out_tx[l] = r_shift[l][SLOT-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SYNC;
      r_sync_cnt  <= '0;
      r_bit_cnt   <= LAST_BIT;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_active    <= 1'b0;
    end else begin
      // Accept never coincides with an unload because ready requires an empty hold.
      if (w_accept) begin
        r_hold      <= data_in_tx;
        r_hold_full <= 1'b1;
      end
      if (r_bit_cnt == LAST_BIT) begin
        r_bit_cnt <= '0;
        if (r_state == ST_SYNC) begin
          r_shift    <= fill(COM_BYTE);
          r_active   <= 1'b0;
          r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
          if (r_sync_cnt == LAST_SYNC) begin
            r_state <= ST_RUN;
          end
        end else if (r_hold_full) begin
          r_shift     <= stripe(r_hold);
          r_hold_full <= 1'b0;
          r_active    <= 1'b1;
        end else begin
          r_shift  <= fill(IDLE_BYTE);
          r_active <= 1'b0;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        for (int l = 0; l < NUM_LANES; l++) begin
          r_shift[l] <= r_shift[l] << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Scoreboard bench for phy_tx_lanes: a 2-lane and a 4-lane instance, each with a
// monitor that pops expected lane bits whenever the DUT flags an active data cycle.
module tb_phy_tx_lanes;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic        clk = 1'b0;
  logic        reset2, reset4;
  logic [31:0] data2, data4;
  logic        valid2, valid4;
  logic        ready2, ready4;
  logic [1:0]  dout2;
  logic [3:0]  dout4;
  logic        act2, act4;

  int n_checks = 0;
  int n_pass   = 0;
  int ph2 = 0;
  int ph4 = 0;
  logic [1:0] q2[$];
  logic [3:0] q4[$];

  always #5 clk = ~clk;

  phy_tx_lanes #(.WORD_W(32), .NUM_LANES(2)) dut2 (
    .clk(clk), .reset(reset2), .data_in_tx(data2), .valid_in_tx(valid2),
    .ready_out_tx(ready2), .data_out_tx(dout2), .active_out_tx(act2)
  );

  phy_tx_lanes #(.WORD_W(32), .NUM_LANES(4)) dut4 (
    .clk(clk), .reset(reset4), .data_in_tx(data4), .valid_in_tx(valid4),
    .ready_out_tx(ready4), .data_out_tx(dout4), .active_out_tx(act4)
  );

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, what, act, exp, $time);
  endtask

  // Hand-written per-lane byte sequences, MSB first.
  task automatic push2(input logic [15:0] l0, input logic [15:0] l1, input int nb);
    for (int i = 0; i < nb; i++) q2.push_back({l1[15-i], l0[15-i]});
  endtask

  task automatic push4(input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [7:0] l3);
    for (int i = 0; i < 8; i++) q4.push_back({l3[7-i], l2[7-i], l1[7-i], l0[7-i]});
  endtask

  always @(negedge clk) begin
    if (act2) begin
      if (q2.size() == 0) begin
        n_checks++;
        $display("FAIL mon2/lanes: unexpected data cycle lanes=%b expected none at %0t", dout2, $time);
      end else begin
        chk("mon2", "lanes", 32'(dout2), 32'(q2.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (act4) begin
      if (q4.size() == 0) begin
        n_checks++;
        $display("FAIL mon4/lanes: unexpected data cycle lanes=%b expected none at %0t", dout4, $time);
      end else begin
        chk("mon4", "lanes", 32'(dout4), 32'(q4.pop_front()));
      end
    end
  end

  task automatic cyc2(input string tag, input logic er, input logic ea,
                      input logic [7:0] fb, input bit chkfill);
    @(negedge clk);
    chk(tag, "ready", 32'(ready2), 32'(er));
    chk(tag, "active", 32'(act2), 32'(ea));
    if (chkfill) chk(tag, "fill", 32'(dout2), 32'({2{fb[7 - (ph2 % 8)]}}));
    ph2++;
  endtask

  task automatic cyc4(input string tag, input logic er, input logic ea,
                      input logic [7:0] fb, input bit chkfill);
    @(negedge clk);
    chk(tag, "ready", 32'(ready4), 32'(er));
    chk(tag, "active", 32'(act4), 32'(ea));
    if (chkfill) chk(tag, "fill", 32'(dout4), 32'({4{fb[7 - (ph4 % 8)]}}));
    ph4++;
  endtask

  initial begin
    reset2 = 1'b0; reset4 = 1'b0;
    valid2 = 1'b0; valid4 = 1'b0;
    data2 = '0;    data4 = '0;
    repeat (3) @(negedge clk);
    chk("reset", "dout2", 32'(dout2), 32'd0);
    chk("reset", "ready2", 32'(ready2), 32'd0);
    chk("reset", "act2", 32'(act2), 32'd0);
    chk("reset", "dout4", 32'(dout4), 32'd0);
    chk("reset", "ready4", 32'(ready4), 32'd0);

    // COM preamble: two 16-cycle slots, ready after the second COM load
    reset2 = 1'b1; ph2 = 0;
    for (int i = 0; i < 32; i++) cyc2("sync", (i >= 16), 1'b0, COM, 1'b1);
    for (int i = 0; i < 16; i++) cyc2("idle", 1'b1, 1'b0, IDLE, 1'b1);

    // Single word; accept lands on a boundary, so one IDLE slot precedes it
    valid2 = 1'b1; data2 = 32'hA1B2C3D4;
    push2(16'hA1C3, 16'hB2D4, 16);
    cyc2("w1wait", 1'b0, 1'b0, IDLE, 1'b1);
    valid2 = 1'b0;
    for (int i = 0; i < 15; i++) cyc2("w1wait", 1'b0, 1'b0, IDLE, 1'b1);
    for (int i = 0; i < 16; i++) cyc2("w1data", 1'b1, 1'b1, IDLE, 1'b0);

    // Back-to-back words with valid held high
    valid2 = 1'b1; data2 = 32'h11223344;
    push2(16'h1133, 16'h2244, 16);
    cyc2("strm", 1'b0, 1'b0, IDLE, 1'b1);
    data2 = 32'h55667788;
    push2(16'h5577, 16'h6688, 16);
    for (int i = 0; i < 15; i++) cyc2("strm", 1'b0, 1'b0, IDLE, 1'b1);
    cyc2("strm_a", 1'b1, 1'b1, IDLE, 1'b0);
    cyc2("strm_a", 1'b0, 1'b1, IDLE, 1'b0);
    valid2 = 1'b0;
    for (int i = 0; i < 14; i++) cyc2("strm_a", 1'b0, 1'b1, IDLE, 1'b0);
    for (int i = 0; i < 16; i++) cyc2("strm_b", 1'b1, 1'b1, IDLE, 1'b0);

    // Reset after bit 5 of a data slot, with a second word sitting in the hold
    valid2 = 1'b1; data2 = 32'hF0E1D2C3;
    push2(16'hF0D2, 16'hE1C3, 6);
    cyc2("abort", 1'b0, 1'b0, IDLE, 1'b1);
    data2 = 32'h0BADBEEF;
    for (int i = 0; i < 15; i++) cyc2("abort", 1'b0, 1'b0, IDLE, 1'b1);
    cyc2("abort_d", 1'b1, 1'b1, IDLE, 1'b0);
    cyc2("abort_d", 1'b0, 1'b1, IDLE, 1'b0);
    valid2 = 1'b0;
    for (int i = 0; i < 4; i++) cyc2("abort_d", 1'b0, 1'b1, IDLE, 1'b0);
    #1 reset2 = 1'b0;
    #1;
    chk("midrst", "dout2", 32'(dout2), 32'd0);
    chk("midrst", "ready2", 32'(ready2), 32'd0);
    chk("midrst", "act2", 32'(act2), 32'd0);
    @(negedge clk);
    chk("midrst", "ready2_held", 32'(ready2), 32'd0);
    reset2 = 1'b1; ph2 = 0;
    for (int i = 0; i < 32; i++) cyc2("resync", (i >= 16), 1'b0, COM, 1'b1);
    for (int i = 0; i < 16; i++) cyc2("noheld", 1'b1, 1'b0, IDLE, 1'b1);

    // Four lanes, 8-cycle slots; valid raised during SYNC waits for ready
    reset4 = 1'b1; ph4 = 0;
    valid4 = 1'b1; data4 = 32'hA1B2C3D4;
    push4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    for (int i = 0; i < 32; i++) begin
      cyc4("l4", (i == 8) || (i >= 16), (i >= 16) && (i < 24),
           (i < 16) ? COM : IDLE, !((i >= 16) && (i < 24)));
      if (i == 9) valid4 = 1'b0;
    end

    chk("end", "q2_left", 32'(q2.size()), 32'd0);
    chk("end", "q4_left", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
